// File: rtl/raw_scoreboard.sv
// RAW-hazard scoreboard: per-register pending-write counters plus rs1/rs2 bypass selection.
// Optional macro RAW_SCB_FORWARD_EN enables ex/wb bypass; otherwise pure interlock.
module raw_scoreboard #(
  parameter int unsigned NR_REG = 16,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_fire,
  input  logic            issue_wen,
  input  logic [4:0]      issue_rd,
  output logic            issue_block,
  input  logic            reg1_read,
  input  logic            reg2_read,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  input  logic            ex_valid,
  input  logic            ex_wen,
  input  logic            ex_load,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            wb_valid,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            rs1_raw,
  output logic            rs1_forward,
  output logic [XLEN-1:0] rs1_value,
  output logic            rs2_raw,
  output logic            rs2_forward,
  output logic [XLEN-1:0] rs2_value,
  output logic            busy,
  output logic            scb_err
);

  localparam int unsigned IDX_W = $clog2(NR_REG);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  cnt_t cnt_q [NR_REG];
  cnt_t cnt_d [NR_REG];
  logic err_q, err_d;

  idx_t issue_idx, wb_idx, ex_idx;
  idx_t raddr_idx [2];
  logic inc_req, dec_req;
  logic [1:0] rd_req, raw, fwd;
  logic [XLEN-1:0] val [2];

  assign issue_idx    = issue_rd[IDX_W-1:0];
  assign wb_idx       = wb_rd[IDX_W-1:0];
  assign ex_idx       = ex_rd[IDX_W-1:0];
  assign raddr_idx[0] = raddr1[IDX_W-1:0];
  assign raddr_idx[1] = raddr2[IDX_W-1:0];
  assign rd_req       = {reg2_read, reg1_read};

  assign inc_req     = issue_fire & issue_wen & (issue_idx != '0);
  assign dec_req     = wb_valid & wb_wen & (wb_idx != '0);
  assign issue_block = issue_wen & (issue_idx != '0) & (cnt_q[issue_idx] == '1);

  // Saturated inc and empty dec hold the counter; a same-cycle inc/dec pair cancels.
  always_comb begin
    for (int unsigned r = 0; r < NR_REG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_req && issue_idx == idx_t'(r) && !(dec_req && wb_idx == idx_t'(r))) begin
        if (cnt_q[r] != '1) cnt_d[r] = cnt_q[r] + cnt_t'(1);
      end else if (dec_req && wb_idx == idx_t'(r) && !(inc_req && issue_idx == idx_t'(r))) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - cnt_t'(1);
      end
    end
    err_d = err_q | (issue_fire & issue_block) | (dec_req & (cnt_q[wb_idx] == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NR_REG; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NR_REG; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned r = 0; r < NR_REG; r++) busy = busy | (cnt_q[r] != '0);
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      raw[p] = rd_req[p] & (raddr_idx[p] != '0) & (cnt_q[raddr_idx[p]] != '0);
    end
  end

`ifdef RAW_SCB_FORWARD_EN
  logic unused_hi;
  assign unused_hi = ^{issue_rd[4:IDX_W], wb_rd[4:IDX_W], ex_rd[4:IDX_W],
                       raddr1[4:IDX_W], raddr2[4:IDX_W]};

  // Bypass only with exactly one producer in flight; ex beats wb as the younger value.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd[p] = 1'b0;
      val[p] = '0;
      if (raw[p] && cnt_q[raddr_idx[p]] == cnt_t'(1)) begin
        if (ex_valid && ex_wen && !ex_load && ex_idx == raddr_idx[p]) begin
          fwd[p] = 1'b1;
          val[p] = ex_result;
        end else if (wb_valid && wb_wen && wb_idx == raddr_idx[p]) begin
          fwd[p] = 1'b1;
          val[p] = wb_data;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{issue_rd[4:IDX_W], wb_rd[4:IDX_W], ex_rd, raddr1[4:IDX_W],
                        raddr2[4:IDX_W], ex_valid, ex_wen, ex_load, ex_result, wb_data,
                        ex_idx};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd[p] = 1'b0;
      val[p] = '0;
    end
  end
`endif

  assign rs1_raw     = raw[0];
  assign rs1_forward = fwd[0];
  assign rs1_value   = val[0];
  assign rs2_raw     = raw[1];
  assign rs2_forward = fwd[1];
  assign rs2_value   = val[1];
  assign scb_err     = err_q;

endmodule

// File: tb/tb_raw_scoreboard.sv
// Scoreboard bench for raw_scoreboard; expectations follow RAW_SCB_FORWARD_EN when defined.
module tb_raw_scoreboard;

`ifdef RAW_SCB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_fire, issue_wen, issue_block;
  logic [4:0]  issue_rd;
  logic        reg1_read, reg2_read;
  logic [4:0]  raddr1, raddr2;
  logic        ex_valid, ex_wen, ex_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        wb_valid, wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rs1_raw, rs1_forward, rs2_raw, rs2_forward, busy, scb_err;
  logic [31:0] rs1_value, rs2_value;

  typedef struct packed {
    logic        err;
    logic        busy;
    logic        blk;
    logic        r1raw;
    logic        r1fwd;
    logic [31:0] r1val;
    logic        r2raw;
    logic        r2fwd;
    logic [31:0] r2val;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  raw_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .issue_fire (issue_fire),
    .issue_wen  (issue_wen),
    .issue_rd   (issue_rd),
    .issue_block(issue_block),
    .reg1_read  (reg1_read),
    .reg2_read  (reg2_read),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .ex_valid   (ex_valid),
    .ex_wen     (ex_wen),
    .ex_load    (ex_load),
    .ex_rd      (ex_rd),
    .ex_result  (ex_result),
    .wb_valid   (wb_valid),
    .wb_wen     (wb_wen),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .rs1_raw    (rs1_raw),
    .rs1_forward(rs1_forward),
    .rs1_value  (rs1_value),
    .rs2_raw    (rs2_raw),
    .rs2_forward(rs2_forward),
    .rs2_value  (rs2_value),
    .busy       (busy),
    .scb_err    (scb_err)
  );

  always #5 clk = ~clk;

  // Monitor: compare every pending expectation against the outputs at the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = exp_q.pop_front();
      o = '{err: scb_err, busy: busy, blk: issue_block, r1raw: rs1_raw, r1fwd: rs1_forward,
            r1val: rs1_value, r2raw: rs2_raw, r2fwd: rs2_forward, r2val: rs2_value};
      n_cmp++;
      if (o !== e.v) begin
        n_bad++;
        $display("FAIL %s: got err=%b busy=%b blk=%b rs1=%b/%b/%h rs2=%b/%b/%h, want err=%b busy=%b blk=%b rs1=%b/%b/%h rs2=%b/%b/%h",
                 e.name, o.err, o.busy, o.blk, o.r1raw, o.r1fwd, o.r1val, o.r2raw, o.r2fwd,
                 o.r2val, e.v.err, e.v.busy, e.v.blk, e.v.r1raw, e.v.r1fwd, e.v.r1val,
                 e.v.r2raw, e.v.r2fwd, e.v.r2val);
      end
    end
  end

  task automatic chk(input string name, input logic err, input logic bsy, input logic blk,
                     input logic r1raw, input logic r1fwd, input logic [31:0] r1val,
                     input logic r2raw, input logic r2fwd, input logic [31:0] r2val);
    exp_t e;
    e.name = name;
    e.v = '{err: err, busy: bsy, blk: blk, r1raw: r1raw, r1fwd: r1fwd, r1val: r1val,
            r2raw: r2raw, r2fwd: r2fwd, r2val: r2val};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_fire = 0; issue_wen = 0; issue_rd = '0;
    reg1_read = 0; reg2_read = 0; raddr1 = '0; raddr2 = '0;
    ex_valid = 0; ex_wen = 0; ex_load = 0; ex_rd = '0; ex_result = '0;
    wb_valid = 0; wb_wen = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_fire = 1; issue_wen = 1; issue_rd = rd;
  endtask

  task automatic read1(input logic [4:0] a);
    reg1_read = 1; raddr1 = a;
  endtask

  task automatic read2(input logic [4:0] a);
    reg2_read = 1; raddr2 = a;
  endtask

  task automatic ex(input logic [4:0] rd, input logic [31:0] d, input logic ld);
    ex_valid = 1; ex_wen = 1; ex_load = ld; ex_rd = rd; ex_result = d;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1; wb_wen = 1; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    idle();
    tick();
    chk("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); rst = 0;
    chk("rst_release", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single producer bypassed from execute, then from writeback.
    tick(); idle(); issue(5);
    chk("issue5", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); idle(); read1(5); read2(6); ex(5, 32'h1234, 0);
    chk("fwd_ex", 0, 1, 0, 1, FWD, FWD ? 32'h1234 : 32'h0, 0, 0, 0);
    tick(); idle(); read1(5); wb(5, 32'h5555);
    chk("fwd_wb", 0, 1, 0, 1, FWD, FWD ? 32'h5555 : 32'h0, 0, 0, 0);
    tick(); idle(); read1(5);
    chk("drained", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load in execute cannot bypass; writeback then supplies the value.
    tick(); idle(); issue(5);
    tick(); idle(); read1(5); ex(5, 32'h9999, 1);
    chk("load_stall", 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tick(); idle(); read1(5); wb(5, 32'hBEEF);
    chk("load_wb", 0, 1, 0, 1, FWD, FWD ? 32'hBEEF : 32'h0, 0, 0, 0);
    tick(); idle(); read1(5);
    chk("load_drained", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Two writers on x5 block bypass; x9 sees ex over wb priority.
    tick(); idle(); issue(5);
    tick(); idle(); issue(5);
    tick(); idle(); issue(9);
    tick(); idle(); read1(5); read2(9); ex(9, 32'hAAAA, 0); wb(9, 32'hBBBB);
    chk("multi", 0, 1, 0, 1, 0, 0, 1, FWD, FWD ? 32'hAAAA : 32'h0);
    tick(); idle(); read2(9); wb(5, 32'h0);
    chk("after_multi", 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-run with cnt[5]=2.
    tick(); idle(); issue(5);
    tick(); idle(); read1(5); issue_wen = 1; issue_rd = 5;
    chk("pre_rst", 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tick(); idle(); rst = 1; read1(5);
    chk("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); rst = 0; idle(); read1(5);
    chk("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Saturation of x7.
    tick(); idle(); issue(7);
    tick(); idle(); issue(7);
    tick(); idle(); issue(7);
    chk("issue7_3rd", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); idle(); issue_wen = 1; issue_rd = 7; read2(7);
    chk("sat_block", 0, 1, 1, 0, 0, 0, 1, 0, 0);
    tick(); idle(); issue(7); wb(7, 32'h0);
    chk("sat_pair", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tick(); idle(); issue_wen = 1; issue_rd = 7;
    chk("sat_hold", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    tick(); idle(); rst = 1;
    chk("rst_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); rst = 0;

    // x0 never tracked; underflow sets sticky error.
    tick(); idle(); issue(0); read1(0);
    chk("x0_issue", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); idle(); read1(0); issue_wen = 1; issue_rd = 0;
    chk("x0_read", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); idle(); wb(3, 32'h77); read1(3);
    chk("underflow_cyc", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); idle(); read1(3);
    chk("underflow_err", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); idle();
    chk("err_sticky", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); rst = 1;
    chk("err_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); rst = 0;
    tick();
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
